// File: rtl/handshake_cond_br_buffered_pkg.sv
// handshake_cond_br_buffered_pkg: branch direction encodings and default widths for the buffered conditional branch
package handshake_cond_br_buffered_pkg;
   localparam logic BR_TRUE       = 1'b1;
   localparam logic BR_FALSE      = 1'b0;
   localparam int   DATA_TYPE_DEF = 32;
   localparam int   CNT_WIDTH_DEF = 16;
endpackage

// File: rtl/handshake_cond_br_slot.sv
// handshake_cond_br_slot: one-entry registered buffer that cuts the data/valid path while keeping full throughput
module handshake_cond_br_slot #(
   parameter int DATA_TYPE = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_TYPE-1:0] in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [DATA_TYPE-1:0] out_data,
   output logic                 out_valid,
   input  logic                 out_ready
);
   logic [DATA_TYPE-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 load;
   // a full slot can refill in the same cycle it drains
   assign in_ready  = !valid_q || out_ready;
   assign load      = in_valid && in_ready;
   assign out_data  = data_q;
   assign out_valid = valid_q;
   always_comb begin
      data_d  = load ? in_data : data_q;
      valid_d = load ? 1'b1 : (out_ready ? 1'b0 : valid_q);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end
endmodule

// File: rtl/handshake_cond_br_buffered.sv
// handshake_cond_br_buffered: joined condition/data branch into buffered true/false slots; COND_BR_TOKEN_CNT_EN adds token counters
module handshake_cond_br_buffered
   import handshake_cond_br_buffered_pkg::*;
#(
   parameter int DATA_TYPE = DATA_TYPE_DEF,
   parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 condition,
   input  logic                 condition_valid,
   output logic                 condition_ready,
   input  logic [DATA_TYPE-1:0] data,
   input  logic                 data_valid,
   output logic                 data_ready,
   output logic [DATA_TYPE-1:0] trueOut,
   output logic                 trueOut_valid,
   input  logic                 trueOut_ready,
   output logic [DATA_TYPE-1:0] falseOut,
   output logic                 falseOut_valid,
`ifdef COND_BR_TOKEN_CNT_EN
   input  logic                 falseOut_ready,
   output logic [CNT_WIDTH-1:0] true_count,
   output logic [CNT_WIDTH-1:0] false_count
`else
   input  logic                 falseOut_ready
`endif
);
   logic t_free, f_free, sel_free, fire, t_load, f_load;
   // readies depend only on the other input's valid and downstream ready, never on our own valid
   assign sel_free        = (condition == BR_TRUE) ? t_free : f_free;
   assign fire            = condition_valid && data_valid && sel_free;
   assign condition_ready = data_valid && sel_free;
   assign data_ready      = condition_valid && sel_free;
   assign t_load          = fire && (condition == BR_TRUE);
   assign f_load          = fire && (condition == BR_FALSE);
   handshake_cond_br_slot #(.DATA_TYPE(DATA_TYPE)) u_true (
      .clk(clk), .rst(rst),
      .in_data(data), .in_valid(t_load), .in_ready(t_free),
      .out_data(trueOut), .out_valid(trueOut_valid), .out_ready(trueOut_ready)
   );
   handshake_cond_br_slot #(.DATA_TYPE(DATA_TYPE)) u_false (
      .clk(clk), .rst(rst),
      .in_data(data), .in_valid(f_load), .in_ready(f_free),
      .out_data(falseOut), .out_valid(falseOut_valid), .out_ready(falseOut_ready)
   );
`ifdef COND_BR_TOKEN_CNT_EN
   logic [CNT_WIDTH-1:0] true_cnt_q, true_cnt_d, false_cnt_q, false_cnt_d;
   always_comb begin
      true_cnt_d  = t_load ? true_cnt_q + 1'b1 : true_cnt_q;
      false_cnt_d = f_load ? false_cnt_q + 1'b1 : false_cnt_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         true_cnt_q  <= '0;
         false_cnt_q <= '0;
      end else begin
         true_cnt_q  <= true_cnt_d;
         false_cnt_q <= false_cnt_d;
      end
   end
   assign true_count  = true_cnt_q;
   assign false_count = false_cnt_q;
`endif
endmodule

// File: tb/tb_handshake_cond_br_buffered.sv
// tb_handshake_cond_br_buffered: directed and scoreboarded checks of routing, join, stall, throughput and reset
module tb_handshake_cond_br_buffered;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        condition = 1'b0, condition_valid = 1'b0, condition_ready;
   logic [31:0] data = '0;
   logic        data_valid = 1'b0, data_ready;
   logic [31:0] trueOut, falseOut;
   logic        trueOut_valid, falseOut_valid;
   logic        trueOut_ready = 1'b1, falseOut_ready = 1'b1;
`ifdef COND_BR_TOKEN_CNT_EN
   logic [15:0] true_count, false_count;
`endif
   int n_cmp = 0, n_bad = 0;

   handshake_cond_br_buffered dut (
      .clk(clk), .rst(rst),
      .condition(condition), .condition_valid(condition_valid), .condition_ready(condition_ready),
      .data(data), .data_valid(data_valid), .data_ready(data_ready),
      .trueOut(trueOut), .trueOut_valid(trueOut_valid), .trueOut_ready(trueOut_ready),
      .falseOut(falseOut), .falseOut_valid(falseOut_valid),
`ifdef COND_BR_TOKEN_CNT_EN
      .falseOut_ready(falseOut_ready),
      .true_count(true_count), .false_count(false_count)
`else
      .falseOut_ready(falseOut_ready)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic cv, input logic c, input logic dv, input logic [31:0] d);
      condition_valid = cv;
      condition = c;
      data_valid = dv;
      data = d;
      #1;
   endtask

   initial begin
      #10_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] qt[$], qf[$];
      logic [31:0] exp_d;
      int sent, cyc, nt, nf;
      // reset state
      tick(); tick();
      chk("rst_t_valid", trueOut_valid, 0);
      chk("rst_f_valid", falseOut_valid, 0);
      chk("rst_t_data", trueOut, 0);
      chk("rst_f_data", falseOut, 0);
`ifdef COND_BR_TOKEN_CNT_EN
      chk("rst_tcnt", true_count, 0);
      chk("rst_fcnt", false_count, 0);
`endif
      // release reset with a true token already presented
      rst = 1'b0;
      drive(1, 1, 1, 32'h2A);
      chk("rel_cond_ready", condition_ready, 1);
      chk("rel_data_ready", data_ready, 1);
      tick();
      chk("route_t_valid", trueOut_valid, 1);
      chk("route_t_data", trueOut, 32'h2A);
      chk("route_f_idle", falseOut_valid, 0);
      drive(1, 0, 1, 32'h7);
      tick();
      chk("route_f_valid", falseOut_valid, 1);
      chk("route_f_data", falseOut, 32'h7);
      chk("route_t_drained", trueOut_valid, 0);
      drive(0, 0, 0, 0);
      tick();
      chk("route_f_drained", falseOut_valid, 0);
      // join: data alone is never consumed
      drive(0, 1, 1, 32'h11);
      for (int i = 0; i < 3; i++) begin
         chk("join_data_ready", data_ready, 0);
         tick();
         chk("join_no_out", trueOut_valid, 0);
      end
      drive(1, 1, 1, 32'h11);
      chk("join_fire_ready", data_ready, 1);
      tick();
      chk("join_t_data", trueOut, 32'h11);
      chk("join_t_valid", trueOut_valid, 1);
      // stall on false path, true path stays independent
      falseOut_ready = 1'b0;
      drive(1, 0, 1, 32'h5);
      tick();
      chk("stall_f5_valid", falseOut_valid, 1);
      chk("stall_f5_data", falseOut, 32'h5);
      drive(1, 0, 1, 32'h6);
      chk("stall_f6_blocked", data_ready, 0);
      chk("stall_f6_cond_blocked", condition_ready, 0);
      tick();
      chk("stall_f5_held", falseOut, 32'h5);
      chk("stall_f5_still_valid", falseOut_valid, 1);
      drive(1, 1, 1, 32'h9);
      chk("indep_t_ready", data_ready, 1);
      tick();
      chk("indep_t_data", trueOut, 32'h9);
      chk("indep_t_valid", trueOut_valid, 1);
      chk("indep_f5_held", falseOut, 32'h5);
      falseOut_ready = 1'b1;
      drive(1, 0, 1, 32'h6);
      chk("drain_refill_ready", data_ready, 1);
      tick();
      chk("refill_f6_data", falseOut, 32'h6);
      chk("refill_f6_valid", falseOut_valid, 1);
      drive(0, 0, 0, 0);
      tick();
      chk("idle_t", trueOut_valid, 0);
      chk("idle_f", falseOut_valid, 0);
      // throughput with random backpressure, per-output scoreboard
      sent = 0; cyc = 0; nt = 0; nf = 0;
      while ((sent < 100 || qt.size() != 0 || qf.size() != 0) && cyc < 2000) begin
         trueOut_ready  = ($urandom_range(0, 9) < 7);
         falseOut_ready = ($urandom_range(0, 9) < 7);
         drive(sent < 100, (sent % 2 == 0), sent < 100, 32'h1000 + sent);
         if (trueOut_valid && trueOut_ready) begin
            exp_d = (qt.size() != 0) ? qt.pop_front() : 32'hDEAD_BEEF;
            chk("tp_true", trueOut, exp_d);
            nt++;
         end
         if (falseOut_valid && falseOut_ready) begin
            exp_d = (qf.size() != 0) ? qf.pop_front() : 32'hDEAD_BEEF;
            chk("tp_false", falseOut, exp_d);
            nf++;
         end
         if (condition_valid && condition_ready) begin
            if (condition) qt.push_back(data);
            else qf.push_back(data);
            sent++;
         end
         tick();
         cyc++;
      end
      chk("tp_in_budget", cyc < 2000, 1);
      chk("tp_true_count", nt, 50);
      chk("tp_false_count", nf, 50);
      drive(0, 0, 0, 0);
      trueOut_ready = 1'b1;
      falseOut_ready = 1'b1;
      tick();
`ifdef COND_BR_TOKEN_CNT_EN
      rst = 1'b1;
      tick();
      rst = 1'b0;
      drive(1, 1, 1, 32'h1);
      repeat (65535) tick();
      chk("cnt_true_max", true_count, 16'hFFFF);
      tick();
      chk("cnt_true_wrap", true_count, 0);
      chk("cnt_false_zero", false_count, 0);
      drive(1, 0, 1, 32'h2);
      tick();
      chk("cnt_false_one", false_count, 1);
      chk("cnt_true_hold", true_count, 0);
`endif
      // mid-operation reset with both slots full
      trueOut_ready = 1'b0;
      falseOut_ready = 1'b0;
      drive(1, 1, 1, 32'hA);
      tick();
      drive(1, 0, 1, 32'hB);
      tick();
      chk("full_t_valid", trueOut_valid, 1);
      chk("full_f_valid", falseOut_valid, 1);
      chk("full_t_data", trueOut, 32'hA);
      chk("full_f_data", falseOut, 32'hB);
      drive(0, 0, 0, 0);
      rst = 1'b1;
      tick();
      chk("mrst_t_valid", trueOut_valid, 0);
      chk("mrst_f_valid", falseOut_valid, 0);
      chk("mrst_t_data", trueOut, 0);
      chk("mrst_f_data", falseOut, 0);
`ifdef COND_BR_TOKEN_CNT_EN
      chk("mrst_tcnt", true_count, 0);
      chk("mrst_fcnt", false_count, 0);
`endif
      rst = 1'b0;
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
